spi_master_ctrl: RTL

SPI master that drives the sck/mosi/ss lines of our spi slave stage and captures its miso reply, one byte per transfer. It runs on the system clock and derives sck by integer division. The host side uses a start/busy/done handshake with parallel tx/rx bytes. Fixed SPI mode 0 (CPOL=0, CPHA=0), LSB first, to match the slave's bit order.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_div.sv | 31 +++
 rtl/spi_master_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states, default sizing and the mode-0 clock
// constants common to the master and the slave stage.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_XFER  = 2'd1,
        SPI_TRAIL = 2'd2
    } spi_state_t;

    localparam int SPI_DEFAULT_DATA_W  = 8;
    localparam int SPI_DEFAULT_CLK_DIV = 4;

    // Mode 0: sck idles low, data is sampled on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// sck half-period timer: counts system clocks while running and emits a one-cycle
// tick every CLK_DIV cycles; clear restarts the count from zero.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_MAX);

    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, LSB first, one DATA_W word per transfer with start/busy/done handshake.
// Define SPI_MASTER_TXBUF_EN to add a one-deep tx holding register for back-to-back transfers.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DEFAULT_DATA_W,
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    spi_state_t        state, state_next;
    logic              tick, load, sck_rise, sck_fall, finish, last_bit;
    logic [DATA_W-1:0] load_data, tx_sh, rx_sh;
    logic [BIT_W-1:0]  bit_cnt;

    assign busy     = (state != SPI_IDLE);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign mosi     = tx_sh[0];

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .clear(load),
        .run  (busy),
        .tick (tick)
    );

`ifdef SPI_MASTER_TXBUF_EN
    logic              hold_full, hold_load;
    logic [DATA_W-1:0] hold_data;

    assign tx_ready  = !hold_full;
    // A start landing on the finishing edge chains directly instead of parking in the buffer.
    assign hold_load = busy && !finish && en && start && !hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (hold_load) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (finish && hold_full) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign tx_ready = !busy;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= SPI_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_data  = tx_data;
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        finish     = 1'b0;
        case (state)
            SPI_IDLE: begin
                if (en && start) begin
                    load       = 1'b1;
                    state_next = SPI_XFER;
                end
            end
            SPI_XFER: begin
                if (tick) begin
                    if (sck == SPI_CPOL) begin
                        sck_rise = 1'b1;
                    end else begin
                        sck_fall = 1'b1;
                        if (last_bit) state_next = SPI_TRAIL;
                    end
                end
            end
            SPI_TRAIL: begin
                if (tick) begin
                    finish     = 1'b1;
                    state_next = SPI_IDLE;
`ifdef SPI_MASTER_TXBUF_EN
                    if (hold_full || (en && start)) begin
                        load       = 1'b1;
                        load_data  = hold_full ? hold_data : tx_data;
                        state_next = SPI_XFER;
                    end
`endif
                end
            end
            default: state_next = SPI_IDLE;
        endcase
    end

    // Later assignments win: a chained load keeps ss_n low on the finishing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck     <= SPI_CPOL;
            ss_n    <= 1'b1;
            done    <= 1'b0;
            rx_data <= '0;
            // NOTE: the shift registers are reset too; mosi and rx_data read them and must be zero after reset.
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                ss_n    <= 1'b1;
                rx_data <= rx_sh;
            end
            if (load) begin
                tx_sh   <= load_data;
                ss_n    <= 1'b0;
                bit_cnt <= '0;
            end
            if (sck_rise) begin
                sck   <= ~SPI_CPOL;
                rx_sh <= {miso, rx_sh[DATA_W-1:1]};
            end
            if (sck_fall) begin
                sck <= SPI_CPOL;
                if (!last_bit) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    tx_sh   <= {1'b0, tx_sh[DATA_W-1:1]};
                end
            end
        end
    end

    always @(posedge clk) begin
        assert (CLK_DIV >= 1 && DATA_W >= 2 && DATA_W <= 32 && SPI_CPHA == 1'b0)
            else $error("spi_master_ctrl: illegal CLK_DIV/DATA_W or unsupported SPI mode");
        assert (!(sck && ss_n))
            else $error("spi_master_ctrl: sck high while ss_n deasserted");
    end

endmodule
